prv_trap_sequencer: RTL
=======================

Name: prv_trap_sequencer

Overview:
- Machine-mode trap controller on the prv side of the CSR/privilege boundary.
- Accepts synchronous exceptions from the pipeline, pending machine interrupts and MRET requests.
- Sequences the single-cycle CSR update pulses (mcause/mepc/mbadaddr/mstatus/mip) and issues a fetch redirect to the trap vector or to mepc.
- One trap or return in flight at a time; the pipeline is held via busy.

Parameters:
- XLEN, 32, data/address width.
- NUM_INT, 3, interrupt sources (MSI, MTI, MEI).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- exc_req  in  1  pipeline exception present (level).
- exc_code  in  4  exception cause code.
- exc_badaddr  in  XLEN  faulting address.
- exc_badaddr_v  in  1  exc_badaddr meaningful.
- mret_req  in  1  MRET committing.
- epc_in  in  XLEN  PC of faulting/return-point instruction.
- pipe_quiesced  in  1  pipeline drained, epc_in is the resume PC.
- msip_in, mtip_in, meip_in  in  1 each  raw interrupt lines.
- mstatus_mie, mstatus_mpie  in  1 each  current mstatus fields.
- mie_msie, mie_mtie, mie_meie  in  1 each  enables.
- mtvec  in  XLEN  base[31:2], mode[1:0] (0 direct, 1 vectored).
- mepc  in  XLEN  current mepc.
- busy  out  1  sequencer active; pipeline stalls.
- mcause_rup / mepc_rup / mbadaddr_rup / mstatus_rup / mip_rup  out  1 each  one-cycle update strobes.
- mcause_next, mepc_next, mbadaddr_next  out  XLEN each.
- mie_next, mpie_next  out  1 each  mstatus fields to write.
- mip_next  out  XLEN  bits 3/7/11 = msip/mtip/meip, others 0.
- redirect_valid  out  1  redirect request.
- redirect_pc  out  XLEN  target.
- redirect_ready  in  1  fetch accepts redirect.

Behaviour:
- Reset (synchronous, RST=1 at CLK edge): state IDLE; all strobes, busy and redirect_valid 0; all *_next outputs 0; latched cause/epc/badaddr 0. Reset mid-sequence aborts with no further strobes.
- Interrupt lines are registered once (r_msip/r_mtip/r_meip). When the registered vector differs from last-written, mip_rup pulses 1 cycle with mip_next = new vector. This runs independently of the FSM state.
- pend = registered & enables, gated by mstatus_mie. Priority MEI(11) > MSI(3) > MTI(7).
- IDLE:
  - exc_req=1 → latch cause={0,exc_code}, epc_in, badaddr; go to WRITE.
  - else mret_req=1 → go to MRET_W.
  - else pend≠0 → go to DRAIN.
  - Precedence: exception > MRET > interrupt.
- DRAIN: busy=1.
  - exc_req=1 → exception path as in IDLE (interrupt dropped).
  - pend becomes 0 → IDLE.
  - pipe_quiesced=1 → latch cause={1,27'b0,code}, epc_in; go to WRITE.
- WRITE: one cycle.
  - mcause_rup=mepc_rup=mstatus_rup=1; mbadaddr_rup=exc_badaddr_v (exceptions only).
  - mie_next=0, mpie_next=mstatus_mie.
  - → REDIRECT with redirect_pc = mtvec base; vectored mode and interrupt: base + 4*code.
- MRET_W: one cycle.
  - mstatus_rup=1; mie_next=mstatus_mpie, mpie_next=1.
  - → REDIRECT with redirect_pc = mepc (sampled this cycle).
- REDIRECT: redirect_valid=1, redirect_pc stable until redirect_ready=1 → IDLE. New requests are ignored until IDLE.
- busy=1 in every state except IDLE.
- Latency:
  - Exception accepted at cycle N: strobes at N+1, redirect_valid from N+2.
  - MRET: same timing.
- Address arithmetic is mod 2^XLEN; the base is forced to a 4-byte boundary.

Decomposition:
- machine_mode_types_pkg gains:
  - trap_state_t enum (IDLE, DRAIN, WRITE, MRET_W, REDIRECT).
  - Cause constants: MSI=3, MTI=7, MEI=11.
  - MTVEC_DIRECT/VECTORED.
- Sub-module prv_int_prio: input synchronizer, enable/global gating, priority encoder (outputs pend_any, pend_code[3:0], mip vector).

Test Plan:
- Illegal instr: exc_req=1, exc_code=2, epc_in=0x100, mtvec=0x200 → N+1 mcause_rup with mcause_next=0x2, mepc_next=0x100, mbadaddr_rup=0, mie_next=0 → N+2 redirect_pc=0x200; hold 3 cycles with redirect_ready=0 → pc stable.
- Timer interrupt, vectored: mtvec=0x301, mstatus_mie=1, mie_mtie=1, mtip_in↑, pipe_quiesced after 4 cycles, epc_in=0x440 → mip_rup with mip_next=0x80; mcause_next=0x80000007, mepc_next=0x440; redirect_pc=0x31C.
- Simultaneous MEI+MTI+MSI pending → mcause_next=0x8000000B; with mstatus_mie=0 → FSM stays IDLE, mip_rup still pulses.
- Exception during DRAIN: exc_req=1, exc_code=5, badaddr_v=1, badaddr=0xDEAD0000 → interrupt abandoned; mcause_next=0x5, mbadaddr_next=0xDEAD0000.
- MRET: mstatus_mpie=1, mepc=0x1234 → mstatus_rup with mie_next=1, mpie_next=1; redirect_pc=0x1234. With exc_req and mret_req asserted together → exception wins.
- RST=1 while in REDIRECT → next cycle redirect_valid=0, busy=0, no strobes.

Source files
------------

// File: rtl/machine_mode_types_pkg.sv
// Shared machine-mode trap types: sequencer state encoding, interrupt cause
// codes and mtvec mode encodings.
package machine_mode_types_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRAIN    = 3'd1,
      WRITE    = 3'd2,
      MRET_W   = 3'd3,
      REDIRECT = 3'd4
   } trap_state_t;

   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
   localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/prv_int_prio.sv
// Machine interrupt front end: registers the raw interrupt lines once,
// applies per-source enables and the global mstatus.MIE gate, and picks the
// highest-priority pending source (MEI > MSI > MTI).
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   msip_in/mtip_in/meip_in  raw interrupt lines
//   mstatus_mie              global machine interrupt enable
//   mie_msie/mtie/meie       per-source enables
//   pend_any, pend_code      an enabled interrupt is pending, and its cause
//   mip_vec                  registered lines at mip bit positions 3/7/11
module prv_int_prio
   import machine_mode_types_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            msip_in,
   input  logic            mtip_in,
   input  logic            meip_in,
   input  logic            mstatus_mie,
   input  logic            mie_msie,
   input  logic            mie_mtie,
   input  logic            mie_meie,
   output logic            pend_any,
   output logic [3:0]      pend_code,
   output logic [XLEN-1:0] mip_vec
);

   logic r_msip_q, r_msip_d;
   logic r_mtip_q, r_mtip_d;
   logic r_meip_q, r_meip_d;
   logic en_msi, en_mti, en_mei;

   always_comb begin
      r_msip_d = msip_in;
      r_mtip_d = mtip_in;
      r_meip_d = meip_in;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_msip_q <= 1'b0;
         r_mtip_q <= 1'b0;
         r_meip_q <= 1'b0;
      end else begin
         r_msip_q <= r_msip_d;
         r_mtip_q <= r_mtip_d;
         r_meip_q <= r_meip_d;
      end
   end

   always_comb begin
      en_msi    = r_msip_q & mie_msie & mstatus_mie;
      en_mti    = r_mtip_q & mie_mtie & mstatus_mie;
      en_mei    = r_meip_q & mie_meie & mstatus_mie;
      pend_any  = en_msi | en_mti | en_mei;
      pend_code = 4'd0;
      if (en_mei)      pend_code = CAUSE_MEI;
      else if (en_msi) pend_code = CAUSE_MSI;
      else if (en_mti) pend_code = CAUSE_MTI;
   end

   always_comb begin
      mip_vec     = '0;
      mip_vec[3]  = r_msip_q;
      mip_vec[7]  = r_mtip_q;
      mip_vec[11] = r_meip_q;
   end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap sequencer. Accepts an exception, a pending interrupt or
// an MRET, emits one cycle of CSR update strobes, then holds a fetch
// redirect until fetch accepts it. busy stalls the pipeline throughout.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   exc_*, epc_in, pipe_quiesced   pipeline exception / resume-PC interface
//   mret_req                       MRET committing
//   msip_in/mtip_in/meip_in        raw interrupt lines
//   mstatus_*, mie_*, mtvec, mepc  current CSR values
//   *_rup, *_next                  CSR update strobes and write data
//   redirect_*                     fetch redirect handshake
//
// state    | meaning
// IDLE     | waiting for exception, MRET or enabled interrupt
// DRAIN    | interrupt pending, waiting for pipeline to quiesce
// WRITE    | strobe mcause/mepc/mstatus (and mbadaddr) for a trap
// MRET_W   | strobe mstatus for a return
// REDIRECT | hold redirect_pc until fetch accepts it
module prv_trap_sequencer
   import machine_mode_types_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_INT = 3
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            exc_req,
   input  logic [3:0]      exc_code,
   input  logic [XLEN-1:0] exc_badaddr,
   input  logic            exc_badaddr_v,
   input  logic            mret_req,
   input  logic [XLEN-1:0] epc_in,
   input  logic            pipe_quiesced,
   input  logic            msip_in,
   input  logic            mtip_in,
   input  logic            meip_in,
   input  logic            mstatus_mie,
   input  logic            mstatus_mpie,
   input  logic            mie_msie,
   input  logic            mie_mtie,
   input  logic            mie_meie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic            busy,
   output logic            mcause_rup,
   output logic            mepc_rup,
   output logic            mbadaddr_rup,
   output logic            mstatus_rup,
   output logic            mip_rup,
   output logic [XLEN-1:0] mcause_next,
   output logic [XLEN-1:0] mepc_next,
   output logic [XLEN-1:0] mbadaddr_next,
   output logic            mie_next,
   output logic            mpie_next,
   output logic [XLEN-1:0] mip_next,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            redirect_ready
);

   trap_state_t     state_q, state_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] badaddr_q, badaddr_d;
   logic            badaddr_v_q, badaddr_v_d;
   logic            is_int_q, is_int_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] mip_last_q, mip_last_d;

   logic            pend_any;
   logic [3:0]      pend_code;
   logic [XLEN-1:0] mip_vec;
   logic [XLEN-1:0] vec_base;

   prv_int_prio #(.XLEN(XLEN)) u_int_prio (
      .CLK         (CLK),
      .RST         (RST),
      .msip_in     (msip_in),
      .mtip_in     (mtip_in),
      .meip_in     (meip_in),
      .mstatus_mie (mstatus_mie),
      .mie_msie    (mie_msie),
      .mie_mtie    (mie_mtie),
      .mie_meie    (mie_meie),
      .pend_any    (pend_any),
      .pend_code   (pend_code),
      .mip_vec     (mip_vec)
   );

   // mip tracking runs regardless of the trap FSM.
   always_comb begin
      mip_last_d = mip_vec;
      mip_rup    = (mip_vec != mip_last_q);
      mip_next   = mip_vec;
   end

   assign vec_base = {mtvec[XLEN-1:2], 2'b00};

   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      epc_d       = epc_q;
      badaddr_d   = badaddr_q;
      badaddr_v_d = badaddr_v_q;
      is_int_d    = is_int_q;
      pc_d        = pc_q;

      case (state_q)
         IDLE, DRAIN: begin
            if (exc_req) begin
               cause_d     = {{(XLEN-4){1'b0}}, exc_code};
               epc_d       = epc_in;
               badaddr_d   = exc_badaddr;
               badaddr_v_d = exc_badaddr_v;
               is_int_d    = 1'b0;
               state_d     = WRITE;
            end else if (state_q == IDLE) begin
               if (mret_req)      state_d = MRET_W;
               else if (pend_any) state_d = DRAIN;
            end else if (!pend_any) begin
               state_d = IDLE;
            end else if (pipe_quiesced) begin
               cause_d     = {1'b1, {(XLEN-5){1'b0}}, pend_code};
               epc_d       = epc_in;
               badaddr_v_d = 1'b0;
               is_int_d    = 1'b1;
               state_d     = WRITE;
            end
         end
         WRITE: begin
            // Vectored offset is 4*code from the word-aligned base.
            if (is_int_q && mtvec[1:0] == MTVEC_VECTORED)
               pc_d = vec_base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00};
            else
               pc_d = vec_base;
            state_d = REDIRECT;
         end
         MRET_W: begin
            pc_d    = mepc;
            state_d = REDIRECT;
         end
         REDIRECT: begin
            if (redirect_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy           = (state_q != IDLE);
      mcause_rup     = (state_q == WRITE);
      mepc_rup       = (state_q == WRITE);
      mbadaddr_rup   = (state_q == WRITE) && badaddr_v_q;
      mstatus_rup    = (state_q == WRITE) || (state_q == MRET_W);
      mie_next       = (state_q == MRET_W) ? mstatus_mpie : 1'b0;
      mpie_next      = (state_q == MRET_W) ? 1'b1 :
                       (state_q == WRITE)  ? mstatus_mie : 1'b0;
      mcause_next    = cause_q;
      mepc_next      = epc_q;
      mbadaddr_next  = badaddr_q;
      redirect_valid = (state_q == REDIRECT);
      redirect_pc    = pc_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         cause_q     <= '0;
         epc_q       <= '0;
         badaddr_q   <= '0;
         badaddr_v_q <= 1'b0;
         is_int_q    <= 1'b0;
         pc_q        <= '0;
         mip_last_q  <= '0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         epc_q       <= epc_d;
         badaddr_q   <= badaddr_d;
         badaddr_v_q <= badaddr_v_d;
         is_int_q    <= is_int_d;
         pc_q        <= pc_d;
         mip_last_q  <= mip_last_d;
      end
   end

endmodule
